branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 90 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 16-entry BTB with 2-bit counters, combinational fetch prediction and execute-stage update.
// Define BP_GSHARE_EN to XOR a 4-bit global history register into the fetch index.
module branch_predictor (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    output logic [3:0]  PredIndexF,
    input  logic        ValidE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        ActualTakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] TargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    input  logic [3:0]  PredIndexE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
);
    logic        valid_q [16];
    logic [25:0] tag_q   [16];
    logic [31:0] tgt_q   [16];
    logic [1:0]  ctr_q   [16];
    logic        hit_f;
    logic        br_e;
    logic        taken_e;
    logic        hit_e;
    logic        alias_e;
    logic        upd_e;
    logic [1:0]  ctr_e;
    logic [1:0]  ctr_d;
    logic        unused_bits;

`ifdef BP_GSHARE_EN
    logic [3:0] ghr_q;
    assign PredIndexF = PCF[5:2] ^ ghr_q;
    always_ff @(posedge clk) begin
        if (reset)
            ghr_q <= 4'b0000;
        else if (ValidE && BranchE && !JumpE)
            ghr_q <= {ghr_q[2:0], ActualTakenE};
    end
`else
    assign PredIndexF = PCF[5:2];
`endif

    assign hit_f       = valid_q[PredIndexF] && tag_q[PredIndexF] == PCF[31:6];
    assign PredTakenF  = !reset && hit_f && ctr_q[PredIndexF][1];
    assign PredTargetF = PredTakenF ? tgt_q[PredIndexF] : PCF + 32'd4;

    assign br_e    = BranchE | JumpE;
    assign taken_e = JumpE | (BranchE & ActualTakenE);
    assign alias_e = !br_e && PredTakenE;
    assign upd_e   = ValidE && (br_e || alias_e);
    assign ctr_e   = ctr_q[PredIndexE];
    assign hit_e   = valid_q[PredIndexE] && tag_q[PredIndexE] == PCE[31:6];

    // Miss allocates with a bias toward the observed outcome; hits move the counter by one and saturate.
    assign ctr_d = JumpE ? 2'b11 :
                   !hit_e ? (taken_e ? 2'b10 : 2'b01) :
                   taken_e ? (ctr_e == 2'b11 ? ctr_e : ctr_e + 2'd1) :
                   (ctr_e == 2'b00 ? ctr_e : ctr_e - 2'd1);

    assign MispredictE = ValidE && !reset &&
                         (br_e ? (PredTakenE != taken_e) || (taken_e && PredTakenE && PredTargetE != TargetE)
                               : PredTakenE);
    assign RedirectPCE = taken_e ? TargetE : PCPlus4E;

    assign unused_bits = ^{PCF[1:0], PCE[5:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_e) begin
            valid_q[PredIndexE] <= br_e;
            if (br_e) begin
                tag_q[PredIndexE] <= PCE[31:6];
                ctr_q[PredIndexE] <= ctr_d;
                if (taken_e || !hit_e)
                    tgt_q[PredIndexE] <= TargetE;
            end
        end
    end
endmodule
